// File: rtl/wait_condition_scheduler.sv
// Condition-wait scheduler: per-slot IDLE/DELAY/WAIT/PEND machines watching a shared value,
// with a round-robin arbiter that releases at most one pending slot per cycle.
module wait_condition_scheduler #(
    parameter  int NUM_SLOTS = 4,
    parameter  int VALUE_W   = 32,
    parameter  int DELAY_W   = 8,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [VALUE_W-1:0]   value,
    input  logic                 arm_valid,
    output logic                 arm_ready,
    input  logic [SLOT_W-1:0]    arm_slot,
    input  logic [1:0]           arm_op,
    input  logic [VALUE_W-1:0]   arm_lo,
    input  logic [VALUE_W-1:0]   arm_hi,
    input  logic [DELAY_W-1:0]   arm_delay,
    input  logic [NUM_SLOTS-1:0] cancel,
    output logic                 release_valid,
    output logic [SLOT_W-1:0]    release_slot,
    output logic [NUM_SLOTS-1:0] busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_WAIT  = 2'd2,
        S_PEND  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_EQ    = 2'd0,
        OP_LT    = 2'd1,
        OP_GT    = 2'd2,
        OP_RANGE = 2'd3
    } op_t;

    state_t               r_state     [NUM_SLOTS];
    state_t               w_nextState [NUM_SLOTS];
    op_t                  r_op        [NUM_SLOTS];
    logic [VALUE_W-1:0]   r_lo        [NUM_SLOTS];
    logic [VALUE_W-1:0]   r_hi        [NUM_SLOTS];
    logic [DELAY_W-1:0]   r_cnt       [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] w_armHit;
    logic [NUM_SLOTS-1:0] w_accept;
    logic [NUM_SLOTS-1:0] w_condTrue;
    logic [NUM_SLOTS-1:0] w_grantOh;
    logic                 w_grantValid;
    logic [SLOT_W-1:0]    w_grantSlot;
    logic [SLOT_W-1:0]    w_rrNext;

    logic [SLOT_W-1:0]    r_rr;
    logic                 r_releaseValid;
    logic [SLOT_W-1:0]    r_releaseSlot;

    // Arm handshake: a cancel on the target slot blocks acceptance in the same cycle.
    always_comb begin
        w_armHit  = '0;
        w_accept  = '0;
        arm_ready = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_armHit[i] = (arm_slot == SLOT_W'(i));
            if (w_armHit[i] && (r_state[i] == S_IDLE) && !cancel[i]) begin
                arm_ready = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_accept[i] = arm_valid && w_armHit[i] && (r_state[i] == S_IDLE) && !cancel[i];
        end
    end

    // An empty range (lo >= hi) can never satisfy both strict compares.
    always_comb begin
        w_condTrue = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            case (r_op[i])
                OP_EQ:    w_condTrue[i] = (value == r_lo[i]);
                OP_LT:    w_condTrue[i] = (value <  r_lo[i]);
                OP_GT:    w_condTrue[i] = (value >  r_lo[i]);
                OP_RANGE: w_condTrue[i] = (value > r_lo[i]) && (value < r_hi[i]);
                default:  w_condTrue[i] = 1'b0;
            endcase
        end
    end

    always_comb begin : arbiter
        int idx;
        w_grantValid = 1'b0;
        w_grantSlot  = '0;
        w_grantOh    = '0;
        idx          = 0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_SLOTS) begin
                idx = idx - NUM_SLOTS;
            end
            if (!w_grantValid && (r_state[idx] == S_PEND) && !cancel[idx]) begin
                w_grantValid   = 1'b1;
                w_grantSlot    = SLOT_W'(idx);
                w_grantOh[idx] = 1'b1;
            end
        end
        if (w_grantSlot == SLOT_W'(NUM_SLOTS - 1)) begin
            w_rrNext = '0;
        end else begin
            w_rrNext = w_grantSlot + SLOT_W'(1);
        end
    end

    // Cancel is applied last so it overrides both arm and grant.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_nextState[i] = r_state[i];
            case (r_state[i])
                S_IDLE: begin
                    if (w_accept[i]) begin
                        if (arm_delay == '0) begin
                            w_nextState[i] = S_WAIT;
                        end else begin
                            w_nextState[i] = S_DELAY;
                        end
                    end
                end
                S_DELAY: begin
                    if (r_cnt[i] == DELAY_W'(1)) begin
                        w_nextState[i] = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_condTrue[i]) begin
                        w_nextState[i] = S_PEND;
                    end
                end
                S_PEND: begin
                    if (w_grantOh[i]) begin
                        w_nextState[i] = S_IDLE;
                    end
                end
                default: w_nextState[i] = S_IDLE;
            endcase
            if (cancel[i]) begin
                w_nextState[i] = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= S_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= w_nextState[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_op[i]  <= OP_EQ;
                r_lo[i]  <= '0;
                r_hi[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_accept[i]) begin
                    r_op[i]  <= op_t'(arm_op);
                    r_lo[i]  <= arm_lo;
                    r_hi[i]  <= arm_hi;
                    r_cnt[i] <= arm_delay;
                end else if (r_state[i] == S_DELAY) begin
                    r_cnt[i] <= r_cnt[i] - DELAY_W'(1);
                end
            end
        end
    end

    // release_slot keeps its last value when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr           <= '0;
            r_releaseValid <= 1'b0;
            r_releaseSlot  <= '0;
        end else begin
            r_releaseValid <= w_grantValid;
            if (w_grantValid) begin
                r_releaseSlot <= w_grantSlot;
                r_rr          <= w_rrNext;
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            busy[i] = (r_state[i] != S_IDLE);
        end
    end

    assign release_valid = r_releaseValid;
    assign release_slot  = r_releaseSlot;

endmodule
